// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: sequences glitch-free divider tap changes (old off at its boundary, guard gap, new on at its boundary).
// Optional CLK_DIV_CTRL_TIMEOUT_EN adds a 64-cycle watchdog on the WAIT states; sel_req is held until sel_ack.
module clk_div_ctrl #(
  parameter int NUM_SEL   = 6,
  parameter int GUARD_CYC = 2,
  parameter int RST_SEL   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         div_cnt,
  input  logic               sel_req,
  input  logic [2:0]         sel_val,
  output logic               sel_ack,
  output logic               sel_err,
  output logic [NUM_SEL-1:0] clk_en,
  output logic [2:0]         cur_sel,
  output logic               busy
);

  localparam int                 GW        = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [3:0]         NUM_SEL_W = 4'(NUM_SEL);
  localparam logic [2:0]         RST_IDX   = 3'(RST_SEL);
  localparam logic [NUM_SEL-1:0] RST_EN    = {{(NUM_SEL-1){1'b0}}, 1'b1} << RST_SEL;
  localparam logic [GW-1:0]      GUARD_LD  = GW'(GUARD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OLD = 3'd1,
    GUARD    = 3'd2,
    WAIT_NEW = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_SEL-1:0] en_nxt;
  logic [2:0]         cur_nxt;
  logic [2:0]         tgt, tgt_nxt;
  logic [GW-1:0]      grd, grd_nxt;
  logic               err, err_nxt;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  logic [5:0]         wd, wd_nxt;
`endif

  // Tap s toggles low on the edge after its low s counter bits are all ones.
  function automatic logic at_boundary(input logic [2:0] s, input logic [4:0] cnt);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ((i < int'(s)) && !cnt[i]) b = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [NUM_SEL-1:0] onehot(input logic [2:0] s);
    logic [NUM_SEL-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (int'(s) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_en  <= RST_EN;
      cur_sel <= RST_IDX;
      tgt     <= RST_IDX;
      grd     <= '0;
      err     <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      wd      <= '0;
`endif
    end else begin
      state   <= state_nxt;
      clk_en  <= en_nxt;
      cur_sel <= cur_nxt;
      tgt     <= tgt_nxt;
      grd     <= grd_nxt;
      err     <= err_nxt;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      wd      <= wd_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    en_nxt    = clk_en;
    cur_nxt   = cur_sel;
    tgt_nxt   = tgt;
    grd_nxt   = grd;
    err_nxt   = err;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    wd_nxt    = wd;
`endif
    case (state)
      IDLE: begin
        err_nxt = 1'b0;
        if (sel_req) begin
          tgt_nxt = sel_val;
          if ({1'b0, sel_val} >= NUM_SEL_W) begin
            err_nxt   = 1'b1;
            state_nxt = ACK;
          end else if (sel_val == cur_sel) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WAIT_OLD;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
            wd_nxt    = '0;
`endif
          end
        end
      end
      WAIT_OLD: begin
        if (at_boundary(cur_sel, div_cnt)) begin
          en_nxt    = '0;
          grd_nxt   = GUARD_LD;
          state_nxt = GUARD;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        end else if (wd == 6'h3F) begin
          // Stuck divider: abandon the change while the old tap is still running.
          err_nxt   = 1'b1;
          state_nxt = ACK;
        end else begin
          wd_nxt    = wd + 6'd1;
`endif
        end
      end
      GUARD: begin
        if (grd == '0) begin
          state_nxt = WAIT_NEW;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
          wd_nxt    = '0;
`endif
        end else begin
          grd_nxt = grd - 1'b1;
        end
      end
      WAIT_NEW: begin
        if (at_boundary(tgt, div_cnt)) begin
          en_nxt    = onehot(tgt);
          cur_nxt   = tgt;
          state_nxt = ACK;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        end else if (wd == 6'h3F) begin
          // Undivided tap needs no phase alignment, so it is always safe to fall back to.
          en_nxt    = onehot(3'd0);
          cur_nxt   = 3'd0;
          err_nxt   = 1'b1;
          state_nxt = ACK;
        end else begin
          wd_nxt    = wd + 6'd1;
`endif
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sel_ack = (state == ACK);
  assign sel_err = sel_ack & err;
  assign busy    = (state != IDLE);

  a_en_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(clk_en));

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl against a cycle-timeline reference model of tap changes.
module tb_clk_div_ctrl;

  localparam int NSEL  = 6;
  localparam int GUARD = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      div_cnt;
  logic            sel_req;
  logic [2:0]      sel_val;
  logic            sel_ack;
  logic            sel_err;
  logic [NSEL-1:0] clk_en;
  logic [2:0]      cur_sel;
  logic            busy;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   m_cur = 0;
  bit   run   = 1'b1;
  logic [4:0] dcnt = '0;

  clk_div_ctrl #(.NUM_SEL(NSEL), .GUARD_CYC(GUARD), .RST_SEL(0)) dut (
    .clk(clk), .rst(rst), .div_cnt(div_cnt), .sel_req(sel_req), .sel_val(sel_val),
    .sel_ack(sel_ack), .sel_err(sel_err), .clk_en(clk_en), .cur_sel(cur_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bnd(input int s, input int d);
    return (s == 0) || ((d % (1 << s)) == ((1 << s) - 1));
  endfunction

  function automatic logic [31:0] oh(input int s);
    logic [31:0] v;
    v = 32'd1 << s;
    return v;
  endfunction

  function automatic int dv(input int d0, input int a, input int t);
    return run ? ((d0 + t - a) & 31) : d0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (run) dcnt = dcnt + 5'd1;
    div_cnt = dcnt;
  endtask

  task automatic chk_out(input logic [31:0] en, input int cur, input bit ack, input bit err, input bit bsy);
    chk("clk_en", clk_en, en);
    chk("cur_sel", cur_sel, cur);
    chk("sel_ack", sel_ack, ack);
    chk("sel_err", sel_err, err);
    chk("busy", busy, bsy);
    chk("onehot0", ($countones(clk_en) <= 1), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_out(oh(m_cur), m_cur, 1'b0, 1'b0, 1'b0);
      sel_req = 1'b0;
    end
  endtask

  // Issue a request in the current (idle) cycle with div_cnt = d0 and follow it to completion.
  task automatic do_req(input int val, input int d0);
    int a, t, t_off, t_on, t_ack, old;
    bit err, chg;
    logic [31:0] e;
    old = m_cur;
    dcnt = 5'(d0);
    div_cnt = dcnt;
    sel_req = 1'b1;
    sel_val = 3'(val);
    a = cyc;
    chg = 1'b0; err = 1'b0; t_off = 0; t_on = 0;
    if (val >= NSEL) begin
      err = 1'b1; t_ack = a + 1;
    end else if (val == old) begin
      t_ack = a + 1;
    end else begin
      chg = 1'b1;
      t = a + 1;
      while (!bnd(old, dv(d0, a, t))) t++;
      t_off = t;
      t = t_off + GUARD + 1;
      while (!bnd(val, dv(d0, a, t))) t++;
      t_on = t;
      t_ack = t_on + 1;
    end
    for (int tt = a + 1; tt <= t_ack + 1; tt++) begin
      tick();
      if (!chg || tt <= t_off) e = oh(old);
      else if (tt <= t_on) e = '0;
      else e = oh(val);
      chk_out(e, (chg && tt > t_on) ? val : old, tt == t_ack, (tt == t_ack) && err, tt <= t_ack);
      if (tt < t_ack) begin
        sel_req = 1'($urandom_range(0, 1));
        sel_val = 3'($urandom_range(0, 7));
      end else begin
        sel_req = 1'b0;
      end
    end
    if (chg) m_cur = val;
  endtask

  task automatic reset_in_guard(input int val, input int d0);
    int a, t;
    dcnt = 5'(d0);
    div_cnt = dcnt;
    sel_req = 1'b1;
    sel_val = 3'(val);
    a = cyc;
    t = a + 1;
    while (!bnd(m_cur, dv(d0, a, t))) t++;
    while (cyc < t + 1) begin
      tick();
      sel_req = 1'b0;
    end
    chk("guard_en", clk_en, 0);
    chk("guard_busy", busy, 1);
    rst = 1'b1;
    #1;
    m_cur = 0;
    chk_out(oh(0), 0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out(oh(0), 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic stuck_test();
    int a, ws;
    logic [31:0] e;
    run = 1'b0;
    dcnt = '0;
    div_cnt = dcnt;
    sel_req = 1'b1;
    sel_val = 3'd2;
    a = cyc;
    ws = a + GUARD + 2;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    for (int tt = a + 1; tt <= ws + 65; tt++) begin
      tick();
      sel_req = 1'b0;
      if (tt <= a + 1 || tt >= ws + 64) e = oh(0);
      else e = '0;
      chk_out(e, 0, tt == ws + 64, tt == ws + 64, tt <= ws + 64);
    end
`else
    for (int tt = a + 1; tt <= a + 100; tt++) begin
      tick();
      sel_req = 1'b0;
      chk_out((tt <= a + 1) ? oh(0) : 32'd0, 0, 1'b0, 1'b0, 1'b1);
    end
    rst = 1'b1;
    #1;
    chk_out(oh(0), 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
`endif
    m_cur = 0;
    run = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    sel_req = 1'b0;
    sel_val = '0;
    div_cnt = '0;
    #1;
    chk_out(oh(0), 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    idle(5);

    do_req(3, 0);
    idle(2);
    do_req(5, 5'h0A);
    idle(1);
    do_req(6, 3);
    do_req(7, 9);
    do_req(5, 17);
    idle(1);
    do_req(0, 4);
    do_req(4, 1);
    idle(1);
    reset_in_guard(1, 6);
    idle(2);
    do_req(2, 13);
    idle(1);
    do_req(0, 7);
    idle(1);
    stuck_test();
    idle(2);
    do_req(1, 20);

    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 3));
      do_req($urandom_range(0, 7), $urandom_range(0, 31));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
